// File: rtl/smag_pkg.sv
// rtl/smag_pkg.sv - shared widths, FSM states and zero encodings for the sign-magnitude sorter
package smag_pkg;

    localparam int SMAG_W    = 7;
    localparam int SMAG_SIGN = 6;

    localparam logic [SMAG_W-1:0] POS_ZERO = 7'h00;
    localparam logic [SMAG_W-1:0] NEG_ZERO = 7'h40;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/signed_mag_compare.sv
// rtl/signed_mag_compare.sv - combinational sign-magnitude comparator; -0 and +0 compare equal
module signed_mag_compare
    import smag_pkg::*;
(
    input  logic [SMAG_W-1:0] a,
    input  logic [SMAG_W-1:0] b,
    output logic              aLTb,
    output logic              aGTb,
    output logic              aEQb
);

    logic [SMAG_SIGN-1:0] w_a_mag;
    logic [SMAG_SIGN-1:0] w_b_mag;
    logic                 w_a_zero;
    logic                 w_b_zero;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic                 w_mag_gt;
    logic                 w_mag_lt;
    logic                 w_mag_eq;

    assign w_a_mag  = a[SMAG_SIGN-1:0];
    assign w_b_mag  = b[SMAG_SIGN-1:0];
    assign w_a_zero = ((a & ~NEG_ZERO) == POS_ZERO);
    assign w_b_zero = ((b & ~NEG_ZERO) == POS_ZERO);

    // A negative zero is treated as non-negative so both zero encodings collapse.
    assign w_a_neg  = a[SMAG_SIGN] & ~w_a_zero;
    assign w_b_neg  = b[SMAG_SIGN] & ~w_b_zero;

    assign w_mag_gt = (w_a_mag > w_b_mag);
    assign w_mag_lt = (w_a_mag < w_b_mag);
    assign w_mag_eq = (w_a_mag == w_b_mag);

    assign aEQb = (w_a_neg == w_b_neg) && w_mag_eq;
    assign aGTb = (!w_a_neg &&  w_b_neg)
               || (!w_a_neg && !w_b_neg && w_mag_gt)
               || ( w_a_neg &&  w_b_neg && w_mag_lt);
    assign aLTb = !aGTb && !aEQb;

endmodule

// File: rtl/smag_sort_ctrl.sv
// rtl/smag_sort_ctrl.sv - burst buffer that bubble-sorts sign-magnitude values with one shared comparator
module smag_sort_ctrl
    import smag_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SMAG_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SMAG_W-1:0] out_data,
    output logic              out_last,
    output logic              busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_M1 = CW'(DEPTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SMAG_W-1:0]  r_buf [DEPTH];
    logic [CW-1:0]      r_count;
    logic [CW-1:0]      r_idx;
    logic [CW-1:0]      r_pass;
    logic [CW-1:0]      r_rd;
    logic               r_swapped;

    logic [AW-1:0]      w_ia;
    logic [AW-1:0]      w_ib;
    logic [AW-1:0]      w_ird;
    logic [AW-1:0]      w_iwr;
    logic [SMAG_W-1:0]  w_a;
    logic [SMAG_W-1:0]  w_b;
    logic               w_lt;
    logic               w_gt;
    logic               w_eq;
    logic               w_ordered;

    logic               w_load_fire;
    logic               w_close;
    logic               w_pass_end;
    logic               w_sort_done;
    logic               w_out_fire;

    // Indices never exceed DEPTH-1 where they address the buffer, so the low bits suffice.
    assign w_ia  = r_idx[AW-1:0];
    assign w_ib  = w_ia + 1'b1;
    assign w_ird = r_rd[AW-1:0];
    assign w_iwr = r_count[AW-1:0];
    assign w_a   = r_buf[w_ia];
    assign w_b   = r_buf[w_ib];

    signed_mag_compare u_cmp (
        .a    (w_a),
        .b    (w_b),
        .aLTb (w_lt),
        .aGTb (w_gt),
        .aEQb (w_eq)
    );

    assign w_ordered = w_lt | w_eq;
    assign busy      = (r_state != LOAD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        out_data    = POS_ZERO;
        w_load_fire = 1'b0;
        w_close     = 1'b0;
        w_pass_end  = 1'b0;
        w_sort_done = 1'b0;
        w_out_fire  = 1'b0;
        unique case (r_state)
            LOAD: begin
                in_ready    = 1'b1;
                w_load_fire = in_valid;
                w_close     = in_valid && (in_last || (r_count == DEPTH_M1));
                if (w_close) begin
                    w_state_nxt = (r_count == '0) ? DRAIN : SORT;
                end
            end
            SORT: begin
                w_pass_end  = (r_idx == r_count - CW'(2));
                // The swap decided this cycle counts toward the pass's swapped flag.
                w_sort_done = w_pass_end
                           && (!(r_swapped || !w_ordered) || (r_pass == r_count - CW'(1)));
                if (w_sort_done) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                out_valid  = 1'b1;
                out_data   = r_buf[w_ird];
                out_last   = (r_rd == r_count - CW'(1));
                w_out_fire = out_ready;
                if (w_out_fire && out_last) begin
                    w_state_nxt = LOAD;
                end
            end
            default: begin
                w_state_nxt = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_idx     <= '0;
            r_pass    <= '0;
            r_rd      <= '0;
            r_swapped <= 1'b0;
        end else begin
            if (w_load_fire) begin
                r_count <= r_count + 1'b1;
            end
            if (w_close) begin
                r_idx     <= '0;
                r_pass    <= CW'(1);
                r_swapped <= 1'b0;
                r_rd      <= '0;
            end
            if (r_state == SORT) begin
                if (!w_pass_end) begin
                    r_idx     <= r_idx + 1'b1;
                    r_swapped <= r_swapped | ~w_ordered;
                end else if (w_sort_done) begin
                    r_rd <= '0;
                end else begin
                    r_idx     <= '0;
                    r_pass    <= r_pass + 1'b1;
                    r_swapped <= 1'b0;
                end
            end
            if (w_out_fire) begin
                if (out_last) begin
                    r_count <= '0;
                end else begin
                    r_rd <= r_rd + 1'b1;
                end
            end
        end
    end

    // Buffer contents are never reset; out_data is gated whenever they could be stale.
    always_ff @(posedge clk) begin
        if (w_load_fire) begin
            r_buf[w_iwr] <= in_data;
        end else if ((r_state == SORT) && w_gt) begin
            r_buf[w_ia] <= w_b;
            r_buf[w_ib] <= w_a;
        end
    end

endmodule

// File: tb/tb_smag_sort_ctrl.sv
// tb/tb_smag_sort_ctrl.sv - table, random and corner-case checks of smag_sort_ctrl against a stable-sort model
module tb_smag_sort_ctrl;

    localparam int DEPTH = 8;

    typedef logic [6:0] vec_t [16];
    typedef struct {
        vec_t din;
        int   n;
        bit   use_last;
        int   mode;
        vec_t dexp;
        int   exp_n;
        int   exp_sort;
    } vec_rec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic [6:0] in_data = 7'h00;
    logic       out_ready = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic       out_last;
    logic       busy;
    logic [6:0] out_data;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    smag_sort_ctrl #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
        end
    endtask

    function automatic int key(input logic [6:0] x);
        return x[6] ? -int'(x[5:0]) : int'(x[5:0]);
    endfunction

    // Stable ascending sort: each value goes after every queued value it does not undercut.
    function automatic void model(input vec_t din, input int n, output vec_t dout);
        logic [6:0] q[$];
        for (int i = 0; i < n; i++) begin
            int j = 0;
            while (j < q.size() && key(q[j]) <= key(din[i])) j++;
            q.insert(j, din[i]);
        end
        dout = '{default: 7'h00};
        for (int i = 0; i < q.size(); i++) dout[i] = q[i];
    endfunction

    // exp_sort: >=0 exact SORT cycles, -1 unchecked, -2 bounded by N-1..(N-1)^2
    task automatic run_burst(input int id, input vec_t din, input int n, input bit use_last,
                             input int mode, input vec_t dexp, input int exp_n, input int exp_sort);
        logic [6:0] got[$];
        int         sort_cyc = 0;
        int         cyc = 0;
        bit         done = 0;
        bit         stalled = 0;
        logic [6:0] pd = 7'h00;
        logic       pl = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = din[i];
            in_last  = use_last && (i == n - 1);
            @(negedge clk);
            chk($sformatf("v%0d in_ready beat%0d", id, i), in_ready, (i < DEPTH) ? 1 : 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 7'h00;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (busy && !out_valid) sort_cyc++;
            if (busy) chk($sformatf("v%0d in_ready busy", id), in_ready, 0);
            if (!out_valid) begin
                chk($sformatf("v%0d gated data", id), out_data, 0);
            end else begin
                if (stalled) begin
                    chk($sformatf("v%0d stall data", id), out_data, pd);
                    chk($sformatf("v%0d stall last", id), out_last, pl);
                end
                if (out_ready) begin
                    got.push_back(out_data);
                    chk($sformatf("v%0d last beat%0d", id, got.size() - 1), out_last,
                        (got.size() == exp_n) ? 1 : 0);
                    if (out_last) done = 1;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    pd = out_data;
                    pl = out_last;
                end
            end
            @(posedge clk); #1;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
        chk($sformatf("v%0d completed", id), done, 1);
        chk($sformatf("v%0d beat count", id), got.size(), exp_n);
        for (int i = 0; i < exp_n && i < got.size(); i++)
            chk($sformatf("v%0d data%0d", id, i), got[i], dexp[i]);
        if (exp_sort >= 0) begin
            chk($sformatf("v%0d sort cycles", id), sort_cyc, exp_sort);
        end else if (exp_sort == -2) begin
            if (exp_n >= 2)
                chk($sformatf("v%0d sort cycle bound %0d", id, sort_cyc),
                    (sort_cyc >= exp_n - 1) && (sort_cyc <= (exp_n - 1) * (exp_n - 1)), 1);
            else
                chk($sformatf("v%0d sort cycles", id), sort_cyc, 0);
        end
        @(negedge clk);
        chk($sformatf("v%0d busy after", id), busy, 0);
        chk($sformatf("v%0d in_ready after", id), in_ready, 1);
        chk($sformatf("v%0d out_valid after", id), out_valid, 0);
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    vec_rec_t tbl[7];

    initial begin
        vec_t rin;
        vec_t rexp;
        vec_t tmp;

        tbl[0] = '{din: '{0:7'h05, 1:7'h45, 2:7'h03, 3:7'h7F, 4:7'h00, 5:7'h3F, 6:7'h41, 7:7'h02, default:7'h00},
                   n: 8, use_last: 1, mode: 0,
                   dexp: '{0:7'h7F, 1:7'h45, 2:7'h41, 3:7'h00, 4:7'h02, 5:7'h03, 6:7'h05, 7:7'h3F, default:7'h00},
                   exp_n: 8, exp_sort: -2};
        tbl[1] = '{din: '{0:7'h7F, 1:7'h41, 2:7'h00, 3:7'h01, 4:7'h3F, default:7'h00},
                   n: 5, use_last: 1, mode: 0,
                   dexp: '{0:7'h7F, 1:7'h41, 2:7'h00, 3:7'h01, 4:7'h3F, default:7'h00},
                   exp_n: 5, exp_sort: 4};
        tbl[2] = '{din: '{0:7'h40, 1:7'h00, 2:7'h40, default:7'h00},
                   n: 3, use_last: 1, mode: 0,
                   dexp: '{0:7'h40, 1:7'h00, 2:7'h40, default:7'h00},
                   exp_n: 3, exp_sort: 2};
        tbl[3] = '{din: '{0:7'h25, default:7'h00}, n: 1, use_last: 1, mode: 0,
                   dexp: '{0:7'h25, default:7'h00}, exp_n: 1, exp_sort: 0};
        tbl[4] = '{din: '{0:7'h10, 1:7'h2A, 2:7'h55, 3:7'h00, 4:7'h7F, 5:7'h01, 6:7'h40, 7:7'h3E,
                         8:7'h11, 9:7'h12, default:7'h00},
                   n: 10, use_last: 0, mode: 0,
                   dexp: '{0:7'h7F, 1:7'h55, 2:7'h00, 3:7'h40, 4:7'h01, 5:7'h10, 6:7'h2A, 7:7'h3E, default:7'h00},
                   exp_n: 8, exp_sort: -1};
        tbl[5] = '{din: '{0:7'h3F, 1:7'h20, 2:7'h05, 3:7'h01, 4:7'h41, 5:7'h45, 6:7'h60, 7:7'h7F, default:7'h00},
                   n: 8, use_last: 1, mode: 0,
                   dexp: '{0:7'h7F, 1:7'h60, 2:7'h45, 3:7'h41, 4:7'h01, 5:7'h05, 6:7'h20, 7:7'h3F, default:7'h00},
                   exp_n: 8, exp_sort: 49};
        tbl[6] = tbl[0];
        tbl[6].mode = 1;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset out_data", out_data, 0);
        chk("reset out_last", out_last, 0);
        chk("reset busy", busy, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int t = 0; t < 7; t++)
            run_burst(t, tbl[t].din, tbl[t].n, tbl[t].use_last, tbl[t].mode,
                      tbl[t].dexp, tbl[t].exp_n, tbl[t].exp_sort);

        // Reverse-sorted burst interrupted by reset while sorting.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = tbl[5].din[i];
            in_last  = (i == 7);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (5) @(negedge clk);
        chk("midsort busy", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async reset in_ready", in_ready, 1);
        chk("async reset busy", busy, 0);
        chk("async reset out_valid", out_valid, 0);
        chk("async reset out_data", out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        rin  = '{0:7'h03, 1:7'h01, default:7'h00};
        rexp = '{0:7'h01, 1:7'h03, default:7'h00};
        run_burst(10, rin, 2, 1'b1, 0, rexp, 2, 1);

        for (int r = 0; r < 20; r++) begin
            int  n;
            bit  ul;
            n  = $urandom_range(1, DEPTH);
            ul = !(n == DEPTH && $urandom_range(0, 1) == 1);
            rin = '{default: 7'h00};
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 1) == 1)
                    tmp[0] = {1'($urandom_range(0, 1)), 6'($urandom_range(0, 3))};
                else
                    tmp[0] = 7'($urandom_range(0, 127));
                rin[i] = tmp[0];
            end
            model(rin, n, rexp);
            run_burst(100 + r, rin, n, ul, $urandom_range(0, 2), rexp, n, -2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
